// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation ADC controller.
// Cycle-count helper lets benches and firmware derive conversion latency.
package sar_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StDecide
  } sar_state_e;

  localparam int unsigned DefWidth        = 8;
  localparam int unsigned DefSettleCycles = 4;
  localparam int unsigned DefSyncStages   = 2;

  // Start edge to done edge for one conversion.
  function automatic int unsigned conv_cycles(input int unsigned width,
                                              input int unsigned settle_cycles,
                                              input int unsigned sync_stages);
    return width * (settle_cycles + sync_stages + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchroniser for asynchronous single-bit status inputs.
// Asynchronous active-high reset clears the whole chain.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: drives trial codes onto an external DAC and
// binary-searches the analog input using a synchronised comparator result.
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH         = DefWidth,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
  parameter int unsigned SYNC_STAGES   = DefSyncStages
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + SYNC_STAGES);
  // Settle window covers DAC/comparator settling plus synchroniser latency.
  localparam logic [CntW-1:0]  CntLoad = CntW'(SETTLE_CYCLES + SYNC_STAGES - 1);
  localparam logic [IdxW-1:0]  IdxTop  = IdxW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] One     = WIDTH'(1);

  sar_state_e       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic             done_q, done_d;
  logic             cmp_sync;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_cmp_sync (
    .clk(clk),
    .rst(rst),
    .d  (cmp_in),
    .q  (cmp_sync)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    result_d = result_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StSettle;
          idx_d   = IdxTop;
          cnt_d   = CntLoad;
          work_d  = '0;
        end
      end
      StSettle: begin
        if (abort) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StDecide;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDecide: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          work_d = cmp_sync ? (work_q | (One << idx_q)) : work_q;
          if (idx_q != '0) begin
            idx_d   = idx_q - IdxW'(1);
            cnt_d   = CntLoad;
            state_d = StSettle;
          end else begin
            result_d = work_d;
            done_d   = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // DAC output is registered so the external ladder never sees decode glitches.
    dac_d = (state_d == StIdle) ? '0 : (work_d | (One << idx_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      dac_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      result_q <= result_d;
      dac_q    <= dac_d;
      done_q   <= done_d;
    end
  end

  assign dac_code = dac_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign result   = result_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Randomised self-checking bench for sar_adc_ctrl against an arithmetic SAR model
// driven by an ideal comparator (optionally replaced by asynchronous noise).
module tb_sar_adc_ctrl;

  localparam int unsigned W       = 8;
  localparam int          LATENCY = 8 * (4 + 2 + 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         cmp_in;
  logic [W-1:0] dac_code;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  logic [W-1:0] vin_code = '0;
  bit           noise_en = 1'b0;
  logic         noise = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] trials[$];
  logic [W-1:0] exp_trials[$];

  always #5 clk = ~clk;

  assign cmp_in = noise_en ? noise : (vin_code >= dac_code);

  sar_adc_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .cmp_in  (cmp_in),
    .dac_code(dac_code),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  // Ideal binary search: keep each trial bit when the input is at least the trial code.
  function automatic logic [W-1:0] sar_model(input logic [W-1:0] vin);
    int acc = 0;
    exp_trials.delete();
    for (int b = W - 1; b >= 0; b--) begin
      int trial = acc + (1 << b);
      exp_trials.push_back(W'(trial));
      if (int'(vin) >= trial) acc = trial;
    end
    return W'(acc);
  endfunction

  // Launches a conversion and waits for done, logging every DAC trial code seen.
  task automatic conv(input logic [W-1:0] vin, output int lat, output bit timed_out);
    logic [W-1:0] last = '0;
    vin_code  = vin;
    trials.delete();
    lat       = -1;
    timed_out = 1'b1;
    start     = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && dac_code !== last) begin
        trials.push_back(dac_code);
        last = dac_code;
      end
      if (done) begin
        lat       = n - 1;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (dac_code !== '0) $display("FAIL reset_dac got=%h want=00", dac_code); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else n_pass++;
    n_checks++; if (result !== '0) $display("FAIL reset_result got=%h want=00", result); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_conversions();
    logic [W-1:0] vins[6];
    vins[0] = 8'hA5;
    for (int i = 1; i < 6; i++) vins[i] = W'($urandom_range(0, 255));
    foreach (vins[i]) begin
      int lat;
      bit to;
      logic [W-1:0] exp = sar_model(vins[i]);
      conv(vins[i], lat, to);
      n_checks++;
      if (to || lat != LATENCY) $display("FAIL conv_latency vin=%h got=%0d want=%0d", vins[i], lat, LATENCY);
      else n_pass++;
      n_checks++;
      if (trials != exp_trials) $display("FAIL conv_trials vin=%h got=%p want=%p", vins[i], trials, exp_trials);
      else n_pass++;
      n_checks++; if (result !== exp) $display("FAIL conv_result got=%h want=%h", result, exp); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL conv_busy_after got=%b want=0", busy); else n_pass++;
      @(negedge clk);
      n_checks++; if (done !== 1'b0) $display("FAIL done_one_cycle got=%b want=0", done); else n_pass++;
    end
  endtask

  task automatic test_boundary();
    logic [W-1:0] codes[2];
    codes[0] = 8'h00;
    codes[1] = 8'hFF;
    foreach (codes[i]) begin
      int lat;
      bit to;
      int unstable = 0;
      logic [W-1:0] prev = result;
      // Result must hold its previous value right up to the next done.
      vin_code = codes[i];
      start    = 1'b1;
      to       = 1'b1;
      for (int n = 1; n <= 200; n++) begin
        @(negedge clk);
        start = 1'b0;
        if (done) begin to = 1'b0; break; end
        if (result !== prev) unstable++;
      end
      n_checks++; if (to) $display("FAIL boundary_timeout vin=%h", codes[i]); else n_pass++;
      n_checks++; if (unstable != 0) $display("FAIL boundary_hold_before got=%0d changes want=0", unstable); else n_pass++;
      n_checks++; if (result !== codes[i]) $display("FAIL boundary_result got=%h want=%h", result, codes[i]); else n_pass++;
      unstable = 0;
      vin_code = ~codes[i];
      repeat (10) begin @(negedge clk); if (result !== codes[i]) unstable++; end
      n_checks++; if (unstable != 0) $display("FAIL boundary_hold_after got=%0d changes want=0", unstable); else n_pass++;
    end
  endtask

  task automatic test_abort();
    int lat;
    bit to;
    int seen_done = 0;
    conv(8'h3C, lat, to);
    n_checks++; if (to || result !== 8'h3C) $display("FAIL abort_setup got=%h want=3c", result); else n_pass++;
    vin_code = W'($urandom_range(0, 255));
    start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen_done++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b want=0", busy); else n_pass++;
    n_checks++; if (dac_code !== '0) $display("FAIL abort_dac got=%h want=00", dac_code); else n_pass++;
    repeat (70) begin @(negedge clk); if (done) seen_done++; end
    n_checks++; if (seen_done != 0) $display("FAIL abort_no_done got=%0d want=0", seen_done); else n_pass++;
    n_checks++; if (result !== 8'h3C) $display("FAIL abort_result got=%h want=3c", result); else n_pass++;
    // Abort together with start in idle suppresses the conversion.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_start_idle got=%b want=0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    bit to;
    int seen_done = 0;
    logic [W-1:0] exp;
    vin_code = 8'h5A;
    start = 1'b1;
    repeat (15) begin @(negedge clk); start = 1'b0; end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (dac_code !== '0 || busy !== 1'b0 || done !== 1'b0 || result !== '0)
      $display("FAIL reset_mid_async got=dac %h busy %b done %b res %h want=all 0", dac_code, busy, done, result);
    else n_pass++;
    #7 rst = 1'b0;
    repeat (3) begin @(negedge clk); if (done) seen_done++; end
    n_checks++; if (seen_done != 0 || busy !== 1'b0) $display("FAIL reset_mid_quiet got=%0d dones busy %b want=0", seen_done, busy); else n_pass++;
    exp = sar_model(8'hC3);
    conv(8'hC3, lat, to);
    n_checks++;
    if (to || lat != LATENCY || result !== exp)
      $display("FAIL reset_mid_reconv got=%h lat %0d want=%h lat %0d", result, lat, exp, LATENCY);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat = -1;
    int times[$];
    logic [W-1:0] vin = W'($urandom_range(0, 255));
    logic [W-1:0] exp = sar_model(vin);
    int bad = 0;
    vin_code = vin;
    start = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start = (n == 10 || n == 30) ? 1'b1 : 1'b0;
      if (done) begin lat = n - 1; break; end
    end
    start = 1'b0;
    n_checks++; if (lat != LATENCY) $display("FAIL b2b_ignore_start got=%0d want=%0d", lat, LATENCY); else n_pass++;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 400 && times.size() < 3; n++) begin
      @(negedge clk);
      if (done) begin
        times.push_back(n);
        if (result !== exp) bad++;
      end
    end
    start = 1'b0;
    n_checks++; if (times.size() != 3) $display("FAIL b2b_count got=%0d want=3", times.size()); else n_pass++;
    if (times.size() == 3) begin
      n_checks++;
      if (times[1] - times[0] != LATENCY + 1 || times[2] - times[1] != LATENCY + 1)
        $display("FAIL b2b_spacing got=%0d,%0d want=%0d", times[1] - times[0], times[2] - times[1], LATENCY + 1);
      else n_pass++;
    end
    n_checks++; if (bad != 0) $display("FAIL b2b_result got=%0d bad want=0", bad); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_idle_after got=%b want=0", busy); else n_pass++;
  endtask

  task automatic test_async_cmp();
    for (int k = 0; k < 3; k++) begin
      int lat;
      bit to;
      int xs = 0;
      int badtr = 0;
      noise_en = 1'b1;
      fork
        begin
          while (noise_en) begin
            #($urandom_range(1, 9));
            noise = ~noise;
          end
        end
        begin
          conv(W'($urandom_range(0, 255)), lat, to);
          noise_en = 1'b0;
        end
      join
      foreach (trials[i]) if ($isunknown(trials[i])) xs++;
      if ($isunknown(result)) xs++;
      n_checks++; if (to || xs != 0) $display("FAIL async_no_x got=%0d unknown want=0", xs); else n_pass++;
      // Each trial must keep the higher decisions, set its own bit and clear lower bits.
      if (trials.size() != W || trials[0] !== 8'h80) badtr++;
      else begin
        for (int i = 1; i < W; i++) begin
          int b = W - 1 - i;
          int hi = b + 2;
          logic [W-1:0] mask = W'((1 << (b + 1)) - 1);
          if ((trials[i] & mask) !== W'(1 << b)) badtr++;
          if ((trials[i] >> hi) !== (trials[i-1] >> hi)) badtr++;
        end
        if (result[W-1:1] !== trials[W-1][W-1:1]) badtr++;
      end
      n_checks++; if (badtr != 0) $display("FAIL async_trials got=%p res %h", trials, result); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_conversions();
    test_boundary();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_async_cmp();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
